// File: rtl/control_pipeline.sv
// Control-side pipeline for a 5-stage ARM core: carries decoded control from Decode to Writeback,
// evaluates the condition field in Execute against the NZCV register and gates side effects on it.
module control_pipeline (
  input  logic       clk,
  input  logic       reset,
  input  logic       PCSrcD,
  input  logic       RegWriteD,
  input  logic       MemtoRegD,
  input  logic       MemWriteD,
  input  logic       BranchD,
  input  logic [1:0] FlagWriteD,
  input  logic [3:0] CondD,
  input  logic [3:0] RA1D,
  input  logic [3:0] RA2D,
  input  logic [3:0] WA3D,
  input  logic [3:0] ALUFlagsE,
  input  logic       FlushE,
  output logic [3:0] RA1E,
  output logic [3:0] RA2E,
  output logic [3:0] WA3E,
  output logic       MemtoRegE,
  output logic       PCSrcE,
  output logic       BranchTakenE,
  output logic       RegWriteM,
  output logic       MemWriteM,
  output logic       PCSrcM,
  output logic       MemtoRegM,
  output logic [3:0] WA3M,
  output logic       RegWriteW,
  output logic       MemtoRegW,
  output logic       PCSrcW,
  output logic [3:0] WA3W,
  output logic [3:0] FlagsE
);

  logic       pcsrc_e;
  logic       regwrite_e;
  logic       memwrite_e;
  logic       branch_e;
  logic [1:0] flagwrite_e;
  logic [3:0] cond_e;
  logic       cond_ex_e;

  logic flag_n, flag_z, flag_c, flag_v;
  assign {flag_n, flag_z, flag_c, flag_v} = FlagsE;

  // D/E register; a flush loads an all-zero bubble (Cond=0000, no enables).
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || FlushE) begin
      pcsrc_e     <= 1'b0;
      regwrite_e  <= 1'b0;
      MemtoRegE   <= 1'b0;
      memwrite_e  <= 1'b0;
      branch_e    <= 1'b0;
      flagwrite_e <= 2'b00;
      cond_e      <= 4'b0000;
      RA1E        <= 4'd0;
      RA2E        <= 4'd0;
      WA3E        <= 4'd0;
    end else begin
      pcsrc_e     <= PCSrcD;
      regwrite_e  <= RegWriteD;
      MemtoRegE   <= MemtoRegD;
      memwrite_e  <= MemWriteD;
      branch_e    <= BranchD;
      flagwrite_e <= FlagWriteD;
      cond_e      <= CondD;
      RA1E        <= RA1D;
      RA2E        <= RA2D;
      WA3E        <= WA3D;
    end
  end

  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    cond_ex_e = 1'b0;
    case (cond_e)
      4'b0000: cond_ex_e = flag_z;
      4'b0001: cond_ex_e = ~flag_z;
      4'b0010: cond_ex_e = flag_c;
      4'b0011: cond_ex_e = ~flag_c;
      4'b0100: cond_ex_e = flag_n;
      4'b0101: cond_ex_e = ~flag_n;
      4'b0110: cond_ex_e = flag_v;
      4'b0111: cond_ex_e = ~flag_v;
      4'b1000: cond_ex_e = flag_c & ~flag_z;
      4'b1001: cond_ex_e = ~flag_c | flag_z;
      4'b1010: cond_ex_e = (flag_n == flag_v);
      4'b1011: cond_ex_e = (flag_n != flag_v);
      4'b1100: cond_ex_e = ~flag_z & (flag_n == flag_v);
      4'b1101: cond_ex_e = flag_z | (flag_n != flag_v);
      4'b1110: cond_ex_e = 1'b1;
      default: cond_ex_e = 1'b0;
    endcase
  end

  assign PCSrcE       = pcsrc_e & cond_ex_e;
  assign BranchTakenE = branch_e & cond_ex_e;

  // Flags update from the instruction leaving Execute, even if a bubble is entering behind it.
  always_ff @(posedge clk) begin
    if (reset) begin
      FlagsE <= 4'b0000;
    end else if (cond_ex_e) begin
      if (flagwrite_e[1]) FlagsE[3:2] <= ALUFlagsE[3:2];
      if (flagwrite_e[0]) FlagsE[1:0] <= ALUFlagsE[1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      RegWriteM <= 1'b0;
      MemWriteM <= 1'b0;
      PCSrcM    <= 1'b0;
      MemtoRegM <= 1'b0;
      WA3M      <= 4'd0;
      RegWriteW <= 1'b0;
      MemtoRegW <= 1'b0;
      PCSrcW    <= 1'b0;
      WA3W      <= 4'd0;
    end else begin
      RegWriteM <= regwrite_e & cond_ex_e;
      MemWriteM <= memwrite_e & cond_ex_e;
      PCSrcM    <= PCSrcE;
      MemtoRegM <= MemtoRegE;
      WA3M      <= WA3E;
      RegWriteW <= RegWriteM;
      MemtoRegW <= MemtoRegM;
      PCSrcW    <= PCSrcM;
      WA3W      <= WA3M;
    end
  end

endmodule
